// File: rtl/aq_spsram_bank_arb_if.sv
// ---------------------------------------------------------------------------
// aq_spsram_bank_arb_if
// Requester-side bus of the SRAM bank arbiter.
//   Port A (read-only, fetch side):   a_req, a_addr -> a_gnt, a_rvalid, a_rdata
//   Port B (read/write, refill/debug): b_req, b_wr, b_addr, b_wdata, b_wstrb
//                                      -> b_gnt, b_rvalid, b_rdata
// Modports:
//   master - the requesters (drives requests, receives grants/read data)
//   slave  - the arbiter
// Word address split: bank = addr[BSEL_W-1:0], index = addr[AW-1:BSEL_W].
// ---------------------------------------------------------------------------
interface aq_spsram_bank_arb_if #(
    parameter int BSEL_W = 2
) ();
    localparam int AW = BSEL_W + 11;

    logic          a_req;
    logic [AW-1:0] a_addr;
    logic          a_gnt;
    logic          a_rvalid;
    logic [31:0]   a_rdata;

    logic          b_req;
    logic          b_wr;
    logic [AW-1:0] b_addr;
    logic [31:0]   b_wdata;
    logic [3:0]    b_wstrb;
    logic          b_gnt;
    logic          b_rvalid;
    logic [31:0]   b_rdata;

    modport master (
        output a_req, a_addr,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_wr, b_addr, b_wdata, b_wstrb,
        input  b_gnt, b_rvalid, b_rdata
    );

    modport slave (
        input  a_req, a_addr,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_wr, b_addr, b_wdata, b_wstrb,
        output b_gnt, b_rvalid, b_rdata
    );
endinterface

// File: rtl/aq_spsram_bank_arb.sv
// ---------------------------------------------------------------------------
// aq_spsram_bank_arb
// Shares an N-bank array of 2048x32 single-port SRAMs between two requesters.
// Requests to different banks are served in the same cycle; a same-bank
// conflict is resolved by a round-robin pointer that starts with port A.
// Read data returns exactly one cycle after the grant.
//
// Optional feature: define AQ_SPSRAM_ARB_INIT_EN to zero the whole array
// after reset (2048-cycle sweep, init_done low meanwhile). Without it the
// block is ready in the first cycle after reset is released.
//
// Ports:
//   forever_cpuclk  core clock, rising edge
//   cpurst          synchronous active-high reset
//   bus             aq_spsram_bank_arb_if.slave (ports A and B)
//   init_done       array ready; no grants while low
//   ram_a           per-bank 11-bit index        (N*11)
//   ram_cen         per-bank chip enable, act-low (N)
//   ram_d           per-bank write data          (N*32)
//   ram_gwen        per-bank global write enable, act-low (N)
//   ram_wen         per-bank bit write enable, act-low (N*32)
//   ram_q           per-bank read data, one cycle after an enabled read
// ---------------------------------------------------------------------------
module aq_spsram_bank_arb #(
    parameter int N      = 4,
    parameter int BSEL_W = 2
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst,
    aq_spsram_bank_arb_if.slave   bus,
    output logic                  init_done,
    output logic [N*11-1:0]       ram_a,
    output logic [N-1:0]          ram_cen,
    output logic [N*32-1:0]       ram_d,
    output logic [N-1:0]          ram_gwen,
    output logic [N*32-1:0]       ram_wen,
    input  logic [N*32-1:0]       ram_q
);
    localparam int AW = BSEL_W + 11;

    // Each active-high byte strobe becomes 8 active-low bit write enables.
    function automatic logic [31:0] f_wen_expand(input logic [3:0] strb);
        logic [31:0] wen;
        for (int k = 0; k < 4; k++) begin
            wen[k*8 +: 8] = strb[k] ? 8'h00 : 8'hFF;
        end
        return wen;
    endfunction

    logic [BSEL_W-1:0] w_a_bank;
    logic [BSEL_W-1:0] w_b_bank;
    logic [10:0]       w_a_idx;
    logic [10:0]       w_b_idx;
    logic              w_init;
    logic              w_ready;
    logic [10:0]       w_init_a;
    logic              w_conflict;

    logic              r_rr;          // 0: A holds priority, 1: B holds priority
    logic              r_a_vld_p1;
    logic              r_b_vld_p1;
    logic [BSEL_W-1:0] r_a_bsel_p1;
    logic [BSEL_W-1:0] r_b_bsel_p1;

    assign w_a_bank = bus.a_addr[BSEL_W-1:0];
    assign w_b_bank = bus.b_addr[BSEL_W-1:0];
    assign w_a_idx  = bus.a_addr[AW-1:BSEL_W];
    assign w_b_idx  = bus.b_addr[AW-1:BSEL_W];

`ifdef AQ_SPSRAM_ARB_INIT_EN
    localparam logic [0:0] S_INIT  = 1'b0;
    localparam logic [0:0] S_READY = 1'b1;

    logic [0:0]  r_state;
    logic [10:0] r_cnt;

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
        end else if (r_state == S_INIT) begin
            r_cnt <= r_cnt + 11'd1;
            if (r_cnt == 11'd2047) begin
                r_state <= S_READY;
            end
        end
    end

    // Outputs hold their reset values while reset is asserted.
    assign w_init   = (r_state == S_INIT) && !cpurst;
    assign w_ready  = (r_state == S_READY) && !cpurst;
    assign w_init_a = r_cnt;
`else
    assign w_init   = 1'b0;
    assign w_ready  = !cpurst;
    assign w_init_a = '0;
`endif

    assign init_done = w_ready;

    // Grant (combinational, same cycle as request)
    assign w_conflict  = bus.a_req && bus.b_req && (w_a_bank == w_b_bank);
    assign bus.a_gnt   = w_ready && bus.a_req && (!w_conflict || !r_rr);
    assign bus.b_gnt   = w_ready && bus.b_req && (!w_conflict ||  r_rr);

    // Priority moves to the loser only after an actual conflict.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            r_rr <= 1'b0;
        end else if (w_ready && w_conflict) begin
            r_rr <= ~r_rr;
        end
    end

    // Bank drive. Grants never collide on a bank, so at most one source
    // reaches each SRAM per cycle.
    always_comb begin
        ram_a    = '0;
        ram_cen  = '1;
        ram_d    = '0;
        ram_gwen = '1;
        ram_wen  = '1;
        for (int k = 0; k < N; k++) begin
            if (w_init) begin
                ram_cen[k]         = 1'b0;
                ram_gwen[k]        = 1'b0;
                ram_wen[k*32 +: 32] = '0;
                ram_a[k*11 +: 11]   = w_init_a;
            end else if (bus.a_gnt && (w_a_bank == BSEL_W'(k))) begin
                ram_cen[k]        = 1'b0;
                ram_a[k*11 +: 11] = w_a_idx;
            end else if (bus.b_gnt && (w_b_bank == BSEL_W'(k))) begin
                ram_cen[k]        = 1'b0;
                ram_a[k*11 +: 11] = w_b_idx;
                if (bus.b_wr) begin
                    ram_gwen[k]         = 1'b0;
                    ram_d[k*32 +: 32]   = bus.b_wdata;
                    ram_wen[k*32 +: 32] = f_wen_expand(bus.b_wstrb);
                end
            end
        end
    end

    // Stage p1: read return (valid + registered bank select)
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            r_a_vld_p1 <= 1'b0;
            r_b_vld_p1 <= 1'b0;
        end else begin
            r_a_vld_p1 <= bus.a_gnt;
            r_b_vld_p1 <= bus.b_gnt && !bus.b_wr;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        r_a_bsel_p1 <= w_a_bank;
        r_b_bsel_p1 <= w_b_bank;
    end

    assign bus.a_rvalid = r_a_vld_p1;
    assign bus.b_rvalid = r_b_vld_p1;

    always_comb begin
        bus.a_rdata = '0;
        bus.b_rdata = '0;
        if (r_a_vld_p1) begin
            bus.a_rdata = ram_q[r_a_bsel_p1*32 +: 32];
        end
        if (r_b_vld_p1) begin
            bus.b_rdata = ram_q[r_b_bsel_p1*32 +: 32];
        end
    end
endmodule

// File: tb/tb_aq_spsram_bank_arb.sv
// ---------------------------------------------------------------------------
// tb_aq_spsram_bank_arb
// Directed bench for aq_spsram_bank_arb (N=4). A behavioural SRAM array
// answers the ram_* buses. Stimulus pushes expected read data (with the
// cycle it must appear in) into per-port queues; a monitor pops and
// compares whenever rvalid is seen. Builds with or without
// AQ_SPSRAM_ARB_INIT_EN.
// ---------------------------------------------------------------------------
module tb_aq_spsram_bank_arb;
    localparam int N      = 4;
    localparam int BSEL_W = 2;

    typedef struct {
        logic [31:0] d;
        int          c;
    } exp_t;

    logic           clk;
    logic           cpurst;
    logic           init_done;
    logic [N*11-1:0] ram_a;
    logic [N-1:0]   ram_cen;
    logic [N*32-1:0] ram_d;
    logic [N-1:0]   ram_gwen;
    logic [N*32-1:0] ram_wen;
    logic [N*32-1:0] ram_q;

    logic [31:0]    mem [N][2048];
    exp_t           qa[$];
    exp_t           qb[$];
    int             checks;
    int             errors;
    int             cyc;
    logic           mon_en;

    aq_spsram_bank_arb_if #(.BSEL_W(BSEL_W)) bus ();

    aq_spsram_bank_arb #(.N(N), .BSEL_W(BSEL_W)) dut (
        .forever_cpuclk (clk),
        .cpurst         (cpurst),
        .bus            (bus),
        .init_done      (init_done),
        .ram_a          (ram_a),
        .ram_cen        (ram_cen),
        .ram_d          (ram_d),
        .ram_gwen       (ram_gwen),
        .ram_wen        (ram_wen),
        .ram_q          (ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM array: bit-masked write, registered read.
    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (!ram_cen[k]) begin
                if (!ram_gwen[k]) begin
                    mem[k][ram_a[k*11 +: 11]] <= (mem[k][ram_a[k*11 +: 11]] & ram_wen[k*32 +: 32])
                                               | (ram_d[k*32 +: 32] & ~ram_wen[k*32 +: 32]);
                end else begin
                    ram_q[k*32 +: 32] <= mem[k][ram_a[k*11 +: 11]];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drv(input logic ar, input logic [12:0] aa, input logic br, input logic bw,
                       input logic [12:0] ba, input logic [31:0] wd, input logic [3:0] ws);
        bus.a_req   = ar;
        bus.a_addr  = aa;
        bus.b_req   = br;
        bus.b_wr    = bw;
        bus.b_addr  = ba;
        bus.b_wdata = wd;
        bus.b_wstrb = ws;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic sweep_chk(input int i);
        logic [N*11-1:0] ea;
        for (int k = 0; k < N; k++) ea[k*11 +: 11] = 11'(i);
        chk("sweep_cen",  128'(ram_cen),  128'(0));
        chk("sweep_gwen", 128'(ram_gwen), 128'(0));
        chk("sweep_wen",  128'(ram_wen),  128'(0));
        chk("sweep_d",    128'(ram_d),    128'(0));
        chk("sweep_a",    128'(ram_a),    128'(ea));
        chk("sweep_init_done", 128'(init_done), 128'(0));
        chk("sweep_a_gnt", 128'(bus.a_gnt), 128'(0));
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.a_rvalid) begin
                if (qa.size() == 0) begin
                    chk("a_rvalid_unexpected", 128'(bus.a_rvalid), 128'(0));
                end else begin
                    exp_t e;
                    e = qa.pop_front();
                    chk("a_rdata", 128'(bus.a_rdata), 128'(e.d));
                    chk("a_rvalid_cycle", 128'(cyc), 128'(e.c));
                end
            end else begin
                chk("a_rdata_idle", 128'(bus.a_rdata), 128'(0));
            end
            if (bus.b_rvalid) begin
                if (qb.size() == 0) begin
                    chk("b_rvalid_unexpected", 128'(bus.b_rvalid), 128'(0));
                end else begin
                    exp_t e;
                    e = qb.pop_front();
                    chk("b_rdata", 128'(bus.b_rdata), 128'(e.d));
                    chk("b_rvalid_cycle", 128'(cyc), 128'(e.c));
                end
            end else begin
                chk("b_rdata_idle", 128'(bus.b_rdata), 128'(0));
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        mon_en = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < 2048; j++) begin
`ifdef AQ_SPSRAM_ARB_INIT_EN
                mem[k][j] = 32'hA5A5A5A5;
`else
                mem[k][j] = 32'h0;
`endif
            end
        end
        ram_q  = '0;
        cpurst = 1'b1;
        drv(1'b1, 13'h000, 1'b1, 1'b0, 13'h001, 32'h0, 4'h0);
        next_cycle();
        next_cycle();

        // Reset values (requests present, reset held)
        @(negedge clk);
        chk("rst_a_gnt",    128'(bus.a_gnt),    128'(0));
        chk("rst_b_gnt",    128'(bus.b_gnt),    128'(0));
        chk("rst_a_rvalid", 128'(bus.a_rvalid), 128'(0));
        chk("rst_b_rvalid", 128'(bus.b_rvalid), 128'(0));
        chk("rst_a_rdata",  128'(bus.a_rdata),  128'(0));
        chk("rst_cen",      128'(ram_cen),      128'(4'hF));
        chk("rst_gwen",     128'(ram_gwen),     128'(4'hF));
        chk("rst_wen",      128'(ram_wen),      {128{1'b1}});
        chk("rst_a",        128'(ram_a),        128'(0));
        chk("rst_d",        128'(ram_d),        128'(0));
        mon_en = 1'b1;
        next_cycle();
        cpurst = 1'b0;
        drv(1'b1, 13'h000, 1'b0, 1'b0, 13'h000, 32'h0, 4'h0);

`ifdef AQ_SPSRAM_ARB_INIT_EN
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            sweep_chk(i);
            next_cycle();
        end
        // Reset at sweep cycle 1000
        cpurst = 1'b1;
        @(negedge clk);
        chk("midrst_cen",       128'(ram_cen),   128'(4'hF));
        chk("midrst_init_done", 128'(init_done), 128'(0));
        next_cycle();
        cpurst = 1'b0;
        for (int i = 0; i < 2048; i++) begin
            @(negedge clk);
            sweep_chk(i);
            next_cycle();
        end
`endif
        // First ready cycle: A read of bank0 index0 (zero)
        @(negedge clk);
        chk("ready_init_done", 128'(init_done), 128'(1));
        chk("ready_a_gnt",     128'(bus.a_gnt), 128'(1));
        qa.push_back('{32'h0, cyc + 1});
        next_cycle();

        // Preload with full-strobe B writes
        drv(1'b0, 13'h000, 1'b1, 1'b1, 13'h005, 32'hA1B2C3D4, 4'hF);
        @(negedge clk);
        chk("wr1_b_gnt", 128'(bus.b_gnt), 128'(1));
        chk("wr1_gwen",  128'(ram_gwen),  128'(4'b1101));
        chk("wr1_wen",   128'(ram_wen[32 +: 32]), 128'(0));
        next_cycle();
        drv(1'b0, 13'h000, 1'b1, 1'b1, 13'h006, 32'h55667788, 4'hF);
        @(negedge clk);
        chk("wr2_b_gnt", 128'(bus.b_gnt), 128'(1));
        next_cycle();
        drv(1'b0, 13'h000, 1'b1, 1'b1, 13'h004, 32'h0BADF00D, 4'hF);
        @(negedge clk);
        chk("wr3_b_gnt", 128'(bus.b_gnt), 128'(1));
        next_cycle();

        // Different banks in the same cycle
        drv(1'b1, 13'h005, 1'b1, 1'b0, 13'h006, 32'h0, 4'h0);
        @(negedge clk);
        chk("par_a_gnt", 128'(bus.a_gnt), 128'(1));
        chk("par_b_gnt", 128'(bus.b_gnt), 128'(1));
        chk("par_cen",   128'(ram_cen),   128'(4'b1001));
        qa.push_back('{32'hA1B2C3D4, cyc + 1});
        qb.push_back('{32'h55667788, cyc + 1});
        next_cycle();

        // Same-bank conflict on bank 0 for 4 cycles: A, B, A, B
        drv(1'b1, 13'h000, 1'b1, 1'b0, 13'h004, 32'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_a_gnt", 128'(bus.a_gnt), 128'((i % 2) == 0));
            chk("rr_b_gnt", 128'(bus.b_gnt), 128'((i % 2) == 1));
            chk("rr_cen",   128'(ram_cen),   128'(4'b1110));
            chk("rr_a0",    128'(ram_a[10:0]), 128'((i % 2) == 0 ? 0 : 1));
            if ((i % 2) == 0) qa.push_back('{32'h0, cyc + 1});
            else              qb.push_back('{32'h0BADF00D, cyc + 1});
            next_cycle();
        end

        // Partial-strobe write to bank 3 index 2
        drv(1'b0, 13'h000, 1'b1, 1'b1, 13'h00B, 32'hDEADBEEF, 4'b0101);
        @(negedge clk);
        chk("pw_b_gnt", 128'(bus.b_gnt),           128'(1));
        chk("pw_wen3",  128'(ram_wen[96 +: 32]),   128'(32'hFF00FF00));
        chk("pw_wen_lo", 128'(ram_wen[95:0]),      128'({96{1'b1}}));
        chk("pw_gwen",  128'(ram_gwen),            128'(4'b0111));
        chk("pw_cen",   128'(ram_cen),             128'(4'b0111));
        chk("pw_d3",    128'(ram_d[96 +: 32]),     128'(32'hDEADBEEF));
        chk("pw_d_lo",  128'(ram_d[95:0]),         128'(0));
        chk("pw_a3",    128'(ram_a[33 +: 11]),     128'(2));
        next_cycle();

        // Read back the merged word on A, B reads bank 1 alongside
        drv(1'b1, 13'h00B, 1'b1, 1'b0, 13'h005, 32'h0, 4'h0);
        @(negedge clk);
        chk("rb_a_gnt", 128'(bus.a_gnt), 128'(1));
        chk("rb_b_gnt", 128'(bus.b_gnt), 128'(1));
        qa.push_back('{32'h00AD00EF, cyc + 1});
        qb.push_back('{32'hA1B2C3D4, cyc + 1});
        next_cycle();

        // Back-to-back A reads
        drv(1'b1, 13'h006, 1'b0, 1'b0, 13'h000, 32'h0, 4'h0);
        @(negedge clk);
        chk("b2b1_a_gnt", 128'(bus.a_gnt), 128'(1));
        qa.push_back('{32'h55667788, cyc + 1});
        next_cycle();
        drv(1'b1, 13'h004, 1'b0, 1'b0, 13'h000, 32'h0, 4'h0);
        @(negedge clk);
        chk("b2b2_a_gnt", 128'(bus.a_gnt), 128'(1));
        qa.push_back('{32'h0BADF00D, cyc + 1});
        next_cycle();

        // Conflict on bank 1: priority is back with A, then passes to B
        drv(1'b1, 13'h005, 1'b1, 1'b0, 13'h001, 32'h0, 4'h0);
        @(negedge clk);
        chk("c1_a_gnt", 128'(bus.a_gnt), 128'(1));
        chk("c1_b_gnt", 128'(bus.b_gnt), 128'(0));
        qa.push_back('{32'hA1B2C3D4, cyc + 1});
        next_cycle();
        @(negedge clk);
        chk("c2_a_gnt", 128'(bus.a_gnt), 128'(0));
        chk("c2_b_gnt", 128'(bus.b_gnt), 128'(1));
        chk("c2_a1",    128'(ram_a[11 +: 11]), 128'(0));
        qb.push_back('{32'h0, cyc + 1});
        next_cycle();

        // Idle
        drv(1'b0, 13'h000, 1'b0, 1'b0, 13'h000, 32'h0, 4'h0);
        @(negedge clk);
        chk("idle_cen",   128'(ram_cen),   128'(4'hF));
        chk("idle_a_gnt", 128'(bus.a_gnt), 128'(0));
        next_cycle();

        // Grant immediately followed by reset: its rvalid must not appear
        drv(1'b1, 13'h005, 1'b0, 1'b0, 13'h000, 32'h0, 4'h0);
        @(negedge clk);
        chk("prerst_a_gnt", 128'(bus.a_gnt), 128'(1));
        cpurst = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("postrst_a_rvalid", 128'(bus.a_rvalid), 128'(0));
        chk("postrst_a_gnt",    128'(bus.a_gnt),    128'(0));
        chk("postrst_cen",      128'(ram_cen),      128'(4'hF));
        next_cycle();
        cpurst = 1'b0;

        // First cycle after release
        @(negedge clk);
`ifdef AQ_SPSRAM_ARB_INIT_EN
        chk("rel_init_done", 128'(init_done), 128'(0));
        chk("rel_a_gnt",     128'(bus.a_gnt), 128'(0));
        chk("rel_a",         128'(ram_a),     128'(0));
        chk("rel_cen",       128'(ram_cen),   128'(0));
`else
        chk("rel_init_done", 128'(init_done), 128'(1));
        chk("rel_a_gnt",     128'(bus.a_gnt), 128'(1));
        qa.push_back('{32'hA1B2C3D4, cyc + 1});
`endif
        next_cycle();
        drv(1'b0, 13'h000, 1'b0, 1'b0, 13'h000, 32'h0, 4'h0);
        repeat (3) next_cycle();

        chk("qa_drained", 128'(qa.size()), 128'(0));
        chk("qb_drained", 128'(qb.size()), 128'(0));
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
